// File: rtl/two_phase_pkg.sv
// ---------------------------------------------------------------------------
// two_phase_pkg
//   Shared definitions for the two-phase (transition-signalling) req/ack
//   blocks: the responder state type, the default parameter values and a
//   small helper that turns a req/ack level pair into an "event pending"
//   flag.
// ---------------------------------------------------------------------------
package two_phase_pkg;

    // Responder FSM. A single bit is enough; the encoding is fixed so that
    // waveform viewers and legacy decoders agree on IDLE = 0, BUSY = 1.
    typedef enum logic [0:0] {
        TP_IDLE = 1'b0,
        TP_BUSY = 1'b1
    } tp_resp_state_t;

    localparam int TP_SYNC_STAGES_DEF = 2;
    localparam int TP_LAT_W_DEF       = 8;
    localparam int TP_CNT_W_DEF       = 16;

    // In transition signalling an event is outstanding whenever the
    // request level differs from the acknowledge level.
    function automatic logic tp_pending(input logic req_lvl, input logic ack_lvl);
        return req_lvl ^ ack_lvl;
    endfunction

endpackage

// File: rtl/two_phase_sync.sv
// ---------------------------------------------------------------------------
// two_phase_sync
//   Plain flop-chain synchroniser for a level (two-phase) signal crossing
//   into the clk domain. No logic between stages so the metastability
//   settling time of each stage is a full clock period.
//
// Ports
//   clk  in   sampling clock
//   rst  in   synchronous active-high reset, clears every stage to 0
//   d    in   asynchronous level input
//   q    out  synchronised level (last stage)
//
// STAGES must be at least 2.
// ---------------------------------------------------------------------------
module two_phase_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/two_phase_clocked_responder.sv
// ---------------------------------------------------------------------------
// two_phase_clocked_responder
//   Target side of a single-rail two-phase req/ack handshake. Each req
//   transition is synchronised into clk, held in service for `latency`
//   cycles (sampled when the event is accepted) and answered with exactly
//   one ack transition. Keeps a wrapping count of serviced events and a
//   sticky flag for req changing while an event is in service.
//
// Ports
//   clk          in   sole clock, rising edge
//   rst          in   synchronous active-high reset
//   req          in   two-phase request, asynchronous to clk
//   latency      in   [LAT_W]  service cycles per event
//   clr_err      in   synchronous clear of err (a new error wins)
//   ack          out  two-phase acknowledge, registered
//   busy         out  high while an event is in service
//   done         out  one-cycle pulse in the cycle ack shows its new value
//   event_count  out  [CNT_W]  serviced events modulo 2^CNT_W
//   err          out  sticky protocol-error flag
//
// Latency from the first edge that samples a new req level (E0):
//   E0+SYNC_STAGES            IDLE -> BUSY, cnt loaded
//   E0+SYNC_STAGES+latency+1  ack toggles, done pulses, back to IDLE
// ---------------------------------------------------------------------------
module two_phase_clocked_responder
    import two_phase_pkg::*;
#(
    parameter int SYNC_STAGES = TP_SYNC_STAGES_DEF,
    parameter int LAT_W       = TP_LAT_W_DEF,
    parameter int CNT_W       = TP_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [LAT_W-1:0] latency,
    input  logic             clr_err,
    output logic             ack,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] event_count,
    output logic             err
);

    localparam logic [LAT_W-1:0] LAT_ONE = {{(LAT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    tp_resp_state_t   state;
    logic             req_s;
    logic             req_cap;
    logic [LAT_W-1:0] cnt;
    logic             pending;
    logic             err_set;

    // -----------------------------------------------------------------
    // Request synchroniser
    // -----------------------------------------------------------------
    two_phase_sync #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (req),
        .q   (req_s)
    );

    assign pending = tp_pending(req_s, ack);

    // Any movement of the synchronised request away from the level that
    // was captured on acceptance means the initiator issued another
    // transition before being acknowledged. The event in service still
    // completes; if req ends up toggled twice, pending is seen again on
    // return to IDLE and that second event is serviced normally.
    assign err_set = (state == TP_BUSY) && (req_s != req_cap);

    // -----------------------------------------------------------------
    // FSM, service counter, event counter, error flag
    // -----------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= TP_IDLE;
            cnt         <= '0;
            req_cap     <= 1'b0;
            ack         <= 1'b0;
            done        <= 1'b0;
            event_count <= '0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            // Set has priority over clear.
            err  <= err_set | (err & ~clr_err);

            case (state)
                TP_IDLE: begin
                    if (pending) begin
                        state   <= TP_BUSY;
                        cnt     <= latency;
                        req_cap <= req_s;
                    end
                end
                TP_BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - LAT_ONE;
                    end else begin
                        ack         <= ~ack;
                        done        <= 1'b1;
                        event_count <= event_count + CNT_ONE;
                        state       <= TP_IDLE;
                    end
                end
                default: begin
                    state <= TP_IDLE;
                end
            endcase
        end
    end

    // state is itself a flop, so busy carries no combinational input path.
    assign busy = (state == TP_BUSY);

endmodule

// File: tb/tb_two_phase_clocked_responder.sv
module tb_two_phase_clocked_responder;

    localparam int S  = 2;
    localparam int LW = 8;
    localparam int CW = 4;   // small so the wrap boundary is reachable

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic [LW-1:0] latency;
    logic          clr_err;
    logic          ack, busy, done, err;
    logic [CW-1:0] event_count;

    int n_pass = 0;
    int n_tot  = 0;

    two_phase_clocked_responder #(
        .SYNC_STAGES (S),
        .LAT_W       (LW),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .latency     (latency),
        .clr_err     (clr_err),
        .ack         (ack),
        .busy        (busy),
        .done        (done),
        .event_count (event_count),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------------------------------------------------------
    // Reference model: history of sampled req levels, and a service
    // window scheduled by absolute edge number.
    // ---------------------------------------------------------------
    logic        q_hist[$];
    int unsigned cyc = 0;
    int unsigned m_done_at;
    int          m_count;
    logic        m_ack, m_busy, m_done, m_err, m_cap, m_rs, m_eset;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                q_hist.delete();
                m_ack = 0; m_busy = 0; m_done = 0; m_err = 0; m_cap = 0; m_count = 0;
            end else begin
                // synchronised level as seen before this edge
                m_rs   = (q_hist.size() >= S) ? q_hist[S-1] : 1'b0;
                m_eset = 0;
                m_done = 0;
                if (m_busy) begin
                    m_eset = (m_rs != m_cap);
                    if (cyc == m_done_at) begin
                        m_ack   = ~m_ack;
                        m_done  = 1;
                        m_count = (m_count + 1) % (1 << CW);
                        m_busy  = 0;
                    end
                end else if (m_rs != m_ack) begin
                    m_busy    = 1;
                    m_cap     = m_rs;
                    m_done_at = cyc + latency + 1;
                end
                m_err = m_eset | (m_err & ~clr_err);
                q_hist.push_front(req);
                if (q_hist.size() > S) void'(q_hist.pop_back());
            end
        end
    end

    // Compare every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("m_ack",   ack,         m_ack);
            chk("m_busy",  busy,        m_busy);
            chk("m_done",  done,        m_done);
            chk("m_err",   err,         m_err);
            chk("m_count", event_count, m_count);
        end
    end

    // ---------------------------------------------------------------
    // Directed scenarios with literal expectations
    // ---------------------------------------------------------------
    task automatic do_reset();
        rst = 1; req = 0; clr_err = 0;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic wait_ack(input logic target, output int n);
        n = 0;
        while (ack !== target && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (ack !== target) chk("ack_timeout", ack, target);
    endtask

    int n;

    initial begin
        rst = 1; req = 0; clr_err = 0; latency = '0;
        repeat (2) @(negedge clk);
        rst = 0;
        chk("rst_ack",   ack, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        chk("rst_err",   err, 0);
        chk("rst_count", event_count, 0);

        // single event, latency 5: 2+5+2 = 9 edges
        latency = 8'd5;
        req = 1;
        wait_ack(1'b1, n);
        chk("single_edges", n, 9);
        chk("single_done_hi", done, 1);
        @(negedge clk);
        chk("single_done_lo", done, 0);
        chk("single_count", event_count, 1);
        chk("single_err", err, 0);
        chk("single_busy", busy, 0);

        // back-to-back, latency 0: each event takes 4 edges
        do_reset();
        latency = 8'd0;
        for (int i = 0; i < 10; i++) begin
            req = ~req;
            wait_ack(req, n);
            chk("b2b_edges", n, 4);
        end
        chk("b2b_count", event_count, 10);
        chk("b2b_ack_eq_req", ack, req);

        // protocol error: two toggles 2 cycles apart, latency 20
        do_reset();
        latency = 8'd20;
        req = 1;
        repeat (2) @(negedge clk);
        req = 0;
        repeat (5) @(negedge clk);
        chk("perr_busy", busy, 1);
        chk("perr_err_busy", err, 1);
        wait_ack(1'b1, n);
        chk("perr_first_edges", n, 22 - 5);
        chk("perr_count1", event_count, 1);
        wait_ack(1'b0, n);
        chk("perr_second_edges", n, 22);
        chk("perr_count2", event_count, 2);
        chk("perr_err_sticky", err, 1);
        clr_err = 1;
        @(negedge clk);
        clr_err = 0;
        chk("perr_cleared", err, 0);

        // wrap at CNT_W = 4: 17 events -> 1
        do_reset();
        latency = 8'd0;
        for (int i = 0; i < 17; i++) begin
            req = ~req;
            wait_ack(req, n);
        end
        chk("wrap_count", event_count, 1);

        // reset mid-service
        do_reset();
        latency = 8'd0;
        req = 1;
        wait_ack(1'b1, n);
        latency = 8'd10;
        req = 0;
        n = 0;
        while (!busy && n < 50) begin @(negedge clk); n++; end
        chk("mid_busy", busy, 1);
        repeat (7) @(negedge clk);   // cnt now 3
        rst = 1; req = 0;
        @(negedge clk);
        rst = 0;
        chk("mid_ack", ack, 0);
        chk("mid_busy0", busy, 0);
        chk("mid_count", event_count, 0);
        chk("mid_done", done, 0);
        repeat (20) @(negedge clk);
        chk("mid_quiet_count", event_count, 0);
        chk("mid_quiet_busy", busy, 0);

        // randomized traffic checked against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) req = ~req;
            latency = LW'($urandom_range(0, 6));
            clr_err = ($urandom_range(0, 15) == 0);
            rst     = ($urandom_range(0, 399) == 0);
            if (rst) req = 0;
            @(negedge clk);
        end
        rst = 0; clr_err = 0;
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
